// File: rtl/cordic_pkg.sv
// cordic_pkg: shared sizing, state encoding and elaboration-time constants for
// the CORDIC engine.
//   Q, F            integer/fraction bits of the signed Q.F operand format
//   STAGES, N       clocks per operation and micro-steps unrolled per clock
//   W, ITERS        operand width and total micro-rotations
//   atan_const(i)   atan(2^-i) rounded to nearest Q.F
//   KINV            prod 1/sqrt(1+2^-2i), rounded to nearest Q.F; used only when
//                   the engine is built with CORDIC_GAIN_COMP_EN
package cordic_pkg;

  localparam int unsigned Q      = 4;
  localparam int unsigned F      = 36;
  localparam int unsigned STAGES = 5;
  localparam int unsigned N      = 4;
  localparam int unsigned W      = Q + F;
  localparam int unsigned W2     = 2 * W;
  localparam int unsigned ITERS  = STAGES * N;
  localparam int unsigned KW     = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam int unsigned IW     = (ITERS > 1) ? $clog2(ITERS) : 1;
  // Guard fraction bits used while deriving the rounded constants.
  localparam int unsigned P      = F + 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAIN = 2'd2,
    DONE = 2'd3
  } cordic_state_e;

  // atan(1/m) as a P-bit fraction, Taylor series (m >= 2, or 5/239 for Machin).
  function automatic logic [127:0] atan_recip(input logic [127:0] m);
    logic [127:0] pw;
    logic [127:0] sum;
    logic [127:0] term;
    pw  = (128'd1 << P) / m;
    sum = '0;
    for (int n = 0; n < 64; n++) begin
      term = pw / 128'(2 * n + 1);
      if (n % 2 == 1) sum = sum - term;
      else            sum = sum + term;
      pw = pw / (m * m);
    end
    return sum;
  endfunction

  // atan(2^-i) rounded to nearest Q.F; i = 0 uses Machin's formula for pi/4.
  function automatic logic [W-1:0] atan_const(input int unsigned i);
    logic [127:0] v;
    if (i == 0)       v = 128'd4 * atan_recip(128'd5) - atan_recip(128'd239);
    else if (i >= P)  v = '0;
    else              v = atan_recip(128'd1 << i);
    return W'((v + (128'd1 << (P - F - 1))) >> (P - F));
  endfunction

  // Inverse CORDIC gain: sqrt(prod 1/(1+2^-2i)), with p/(1+a) = p - p/(2^2i+1).
  function automatic logic [W-1:0] kinv_const();
    logic [127:0] p;
    logic [127:0] r;
    logic [127:0] b;
    p = 128'd1 << P;
    for (int unsigned i = 0; i < ITERS; i++) begin
      if (2 * i < P) p = p - p / ((128'd1 << (2 * i)) + 128'd1);
    end
    r = '0;
    for (int j = 63; j >= 0; j--) begin
      b = r | (128'd1 << j);
      if (b * b <= (p << P)) r = b;
    end
    return W'((r + (128'd1 << (P - F - 1))) >> (P - F));
  endfunction

  localparam logic signed [W-1:0] KINV = kinv_const();

endpackage

// File: rtl/cordic_micro_step.sv
// cordic_micro_step: one combinational CORDIC micro-rotation.
//   mode      0 = rotation (steer z to 0), 1 = vectoring (steer y to 0)
//   shift     iteration index i (shift amount)
//   angle     atan(2^-i) in Q.F
//   x, y, z   pre-step values
//   x_c..z_c  post-step values, all arithmetic wrapping modulo 2^W
module cordic_micro_step
  import cordic_pkg::*;
(
  input  logic                mode,
  input  logic [IW-1:0]       shift,
  input  logic signed [W-1:0] angle,
  input  logic signed [W-1:0] x,
  input  logic signed [W-1:0] y,
  input  logic signed [W-1:0] z,
  output logic signed [W-1:0] x_c,
  output logic signed [W-1:0] y_c,
  output logic signed [W-1:0] z_c
);

  logic signed [W-1:0] xs;
  logic signed [W-1:0] ys;
  logic                d;

  // Direction: rotation follows the sign of z, vectoring the sign of y.
  always_comb begin
    xs = x >>> shift;
    ys = y >>> shift;
    d  = mode ? ~y[W-1] : z[W-1];
    if (d) begin
      x_c = x + ys;
      y_c = y - xs;
      z_c = z + angle;
    end else begin
      x_c = x - ys;
      y_c = y + xs;
      z_c = z - angle;
    end
  end

endmodule

// File: rtl/cordic_engine.sv
// cordic_engine: iterative CORDIC, N micro-rotations per clock over STAGES clocks.
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operand handshake; in_ready high only while idle
//   mode                  0 = rotation, 1 = vectoring
//   x_in, y_in, z_in      signed Q.F operands (z in radians)
//   out_valid/out_ready   result handshake; result held until accepted
//   x_out, y_out, z_out   signed Q.F results
//   busy                  high whenever an operation is in flight
// Build option: CORDIC_GAIN_COMP_EN adds a one-clock GAIN state scaling x,y by KINV.
module cordic_engine
  import cordic_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode,
  input  logic [W-1:0] x_in,
  input  logic [W-1:0] y_in,
  input  logic [W-1:0] z_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] x_out,
  output logic [W-1:0] y_out,
  output logic [W-1:0] z_out,
  output logic         busy
);

  cordic_state_e state;
  cordic_state_e state_nxt;
  logic          in_ready_nxt;
  logic          busy_nxt;
  logic          out_valid_nxt;

  logic signed [W-1:0] x_r;
  logic signed [W-1:0] y_r;
  logic signed [W-1:0] z_r;
  logic                mode_r;
  logic [KW-1:0]       k;

  // Next state and registered-output decode.
  always_comb begin
    state_nxt     = state;
    in_ready_nxt  = 1'b0;
    busy_nxt      = 1'b0;
    out_valid_nxt = 1'b0;
    case (state)
      IDLE: if (in_valid) state_nxt = RUN;
      RUN: begin
        if (k == KW'(STAGES - 1)) begin
`ifdef CORDIC_GAIN_COMP_EN
          state_nxt = GAIN;
`else
          state_nxt = DONE;
`endif
        end
      end
      GAIN: state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    in_ready_nxt  = (state_nxt == IDLE);
    busy_nxt      = (state_nxt != IDLE);
    out_valid_nxt = (state_nxt == DONE);
  end

  // State and handshake registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= in_ready_nxt;
      busy      <= busy_nxt;
      out_valid <= out_valid_nxt;
    end
  end

  // atan ROM built from elaboration-time constants.
  logic signed [W-1:0] atan_rom [ITERS];
  for (genvar t = 0; t < ITERS; t++) begin : g_rom
    localparam logic signed [W-1:0] ATAN_T = atan_const(t);
    assign atan_rom[t] = ATAN_T;
  end

  // N chained micro-steps covering iterations k*N .. k*N+N-1.
  logic signed [W-1:0] cx [N+1];
  logic signed [W-1:0] cy [N+1];
  logic signed [W-1:0] cz [N+1];
  logic [IW-1:0]       idx [N];

  assign cx[0] = x_r;
  assign cy[0] = y_r;
  assign cz[0] = z_r;

  for (genvar j = 0; j < N; j++) begin : g_step
    assign idx[j] = IW'(k) * IW'(N) + IW'(j);
    cordic_micro_step u_step (
      .mode  (mode_r),
      .shift (idx[j]),
      .angle (atan_rom[idx[j]]),
      .x     (cx[j]),
      .y     (cy[j]),
      .z     (cz[j]),
      .x_c   (cx[j+1]),
      .y_c   (cy[j+1]),
      .z_c   (cz[j+1])
    );
  end

`ifdef CORDIC_GAIN_COMP_EN
  // Gain compensation: full-width product, truncated back to Q.F.
  logic signed [W2-1:0] gx_prod;
  logic signed [W2-1:0] gy_prod;
  assign gx_prod = W2'(x_r) * W2'(KINV);
  assign gy_prod = W2'(y_r) * W2'(KINV);
`endif

  // Working registers and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r    <= '0;
      y_r    <= '0;
      z_r    <= '0;
      mode_r <= 1'b0;
      k      <= '0;
      x_out  <= '0;
      y_out  <= '0;
      z_out  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_r    <= $signed(x_in);
            y_r    <= $signed(y_in);
            z_r    <= $signed(z_in);
            mode_r <= mode;
            k      <= '0;
          end
        end
        RUN: begin
          x_r <= cx[N];
          y_r <= cy[N];
          z_r <= cz[N];
          k   <= k + KW'(1);
          if (state_nxt == DONE) begin
            x_out <= cx[N];
            y_out <= cy[N];
            z_out <= cz[N];
          end
        end
`ifdef CORDIC_GAIN_COMP_EN
        GAIN: begin
          x_out <= W'(gx_prod >>> F);
          y_out <= W'(gy_prod >>> F);
          z_out <= z_r;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_engine.sv
// tb_cordic_engine: directed bench for cordic_engine with a transaction-level
// reference model (real-valued constants, integer micro-rotations) and a
// per-cycle compare process. Honors CORDIC_GAIN_COMP_EN.
module tb_cordic_engine;

  localparam int  W     = 40;
  localparam int  F     = 36;
  localparam int  ITERS = 20;
  localparam real SCALE = 68719476736.0;
  localparam real PI    = 3.14159265358979323846;
  localparam real TOL   = 1.52587890625e-5;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int  LAT   = 6;
`else
  localparam int  LAT   = 5;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         mode_i;
  logic [W-1:0] x_i, y_i, z_i;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] x_out, y_out, z_out;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  cordic_engine dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode_i), .x_in(x_i), .y_in(y_i), .z_in(z_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .y_out(y_out), .z_out(z_out), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_real(input string nm, input logic [W-1:0] v, input real e);
    real a;
    a = real'(longint'($signed(v))) / SCALE;
    checks++;
    if (a - e > TOL || e - a > TOL) begin
      errors++;
      $display("FAIL %s: got %f expected %f at %0t", nm, a, e, $time);
    end
  endtask

  function automatic logic [W-1:0] to_q(input real r);
    longint v;
    v = longint'($floor(r * SCALE + 0.5));
    return W'(v);
  endfunction

  function automatic longint wrapw(input longint v);
    return (v <<< (64 - W)) >>> (64 - W);
  endfunction

  function automatic real kinv_real();
    real kr;
    kr = 1.0;
    for (int i = 0; i < ITERS; i++) kr = kr / $sqrt(1.0 + 1.0 / (4.0 ** i));
    return kr;
  endfunction

  // Reference: ITERS micro-rotations in plain integer arithmetic.
  task automatic model_op(input logic md, input longint xi, input longint yi,
                          input longint zi, output longint xo, output longint yo,
                          output longint zo);
    longint x, y, z, xs, ys, a;
    logic   d;
    x = xi; y = yi; z = zi;
    for (int i = 0; i < ITERS; i++) begin
      a  = longint'($floor($atan(1.0 / (2.0 ** i)) * SCALE + 0.5));
      d  = md ? (y >= 0) : (z < 0);
      xs = x >>> i;
      ys = y >>> i;
      if (d) begin
        x = wrapw(x + ys); y = wrapw(y - xs); z = wrapw(z + a);
      end else begin
        x = wrapw(x - ys); y = wrapw(y + xs); z = wrapw(z - a);
      end
    end
`ifdef CORDIC_GAIN_COMP_EN
    begin
      logic signed [127:0] pa, pb, kq;
      kq = 128'(longint'($floor(kinv_real() * SCALE + 0.5)));
      pa = 128'(x) * kq;
      pb = 128'(y) * kq;
      x  = wrapw(longint'(pa >>> F));
      y  = wrapw(longint'(pb >>> F));
    end
`endif
    xo = x; yo = y; zo = z;
  endtask

  // Transaction model: accept when idle, result after LAT clocks, held until taken.
  bit     m_pend, m_valid;
  int     m_cnt;
  longint m_x, m_y, m_z, r_x, r_y, r_z;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend = 0; m_valid = 0; m_cnt = 0;
    end else if (m_valid) begin
      if (out_ready) m_valid = 0;
    end else if (m_pend) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_pend = 0; m_valid = 1;
        m_x = r_x; m_y = r_y; m_z = r_z;
      end
    end else if (in_valid) begin
      model_op(mode_i, longint'($signed(x_i)), longint'($signed(y_i)),
               longint'($signed(z_i)), r_x, r_y, r_z);
      m_pend = 1;
      m_cnt  = LAT;
    end
  end

  always @(negedge clk) begin
    check("in_ready", longint'(in_ready), longint'(!(m_pend || m_valid)));
    check("busy", longint'(busy), longint'(m_pend || m_valid));
    check("out_valid", longint'(out_valid), longint'(m_valid));
    if (m_valid) begin
      check("x_out", longint'($signed(x_out)), m_x);
      check("y_out", longint'($signed(y_out)), m_y);
      check("z_out", longint'($signed(z_out)), m_z);
    end
  end

  task automatic issue(input logic md, input real xr, input real yr, input real zr);
    bit acc;
    acc = 0;
    @(negedge clk);
    mode_i = md; x_i = to_q(xr); y_i = to_q(yr); z_i = to_q(zr);
    in_valid = 1;
    for (int n = 0; n < 40 && !acc; n++) begin
      @(posedge clk);
      acc = in_ready;
    end
    check("accept", longint'(acc), 1);
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic wait_result(input string nm);
    int c;
    c = 0;
    while (!out_valid && c < 50) begin
      @(negedge clk);
      c++;
    end
    check(nm, c, LAT);
  endtask

  task automatic release_result();
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    check("idle_after_release", longint'(in_ready), 1);
  endtask

  real kr, grot, gvec;
  int  acc_cyc [3];

  initial begin
    kr = kinv_real();
`ifdef CORDIC_GAIN_COMP_EN
    grot = kr;  gvec = 1.0;
`else
    grot = 1.0; gvec = 1.0 / kr;
`endif
    rst_n = 0; in_valid = 0; out_ready = 0; mode_i = 0;
    x_i = '0; y_i = '0; z_i = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", longint'(in_ready), 1);
    check("rst_busy", longint'(busy), 0);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_x_out", longint'(x_out), 0);
    check("rst_z_out", longint'(z_out), 0);
    rst_n = 1;

    // Rotation by pi/4 from the prescaled unit vector.
    issue(0, 0.607253, 0.0, PI / 4.0);
    wait_result("lat_rot");
    check_real("rot45_x", x_out, 0.707107 * grot);
    check_real("rot45_y", y_out, 0.707107 * grot);
    check_real("rot45_z", z_out, 0.0);
    release_result();

    // Vectoring (1,1), then hold the result under backpressure.
    issue(1, 1.0, 1.0, 0.0);
    wait_result("lat_vec");
    check_real("vec11_x", x_out, $sqrt(2.0) * gvec);
    check_real("vec11_y", y_out, 0.0);
    check_real("vec11_z", z_out, 0.785398);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check("bp_in_ready", longint'(in_ready), 0);
      check("bp_out_valid", longint'(out_valid), 1);
    end
    release_result();

    // Negative angle.
    issue(0, 0.607253, 0.0, -PI / 3.0);
    wait_result("lat_neg");
    check_real("rotm60_x", x_out, 0.5 * grot);
    check_real("rotm60_y", y_out, -0.866025 * grot);
    release_result();

    // Vectoring into the fourth quadrant.
    issue(1, 0.3, -0.4, 0.0);
    wait_result("lat_vec2");
    check_real("vec34_x", x_out, 0.5 * gvec);
    check_real("vec34_z", z_out, -0.927295);
    release_result();

    // Outside the convergence domain: must still complete.
    issue(0, 0.5, 0.5, 3.0);
    wait_result("lat_ood");
    release_result();

    // Reset during RUN.
    issue(0, 0.5, 0.25, 0.3);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("mrst_out_valid", longint'(out_valid), 0);
    check("mrst_in_ready", longint'(in_ready), 1);
    check("mrst_busy", longint'(busy), 0);
    check("mrst_x_out", longint'(x_out), 0);
    check("mrst_y_out", longint'(y_out), 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("post_rst_in_ready", longint'(in_ready), 1);
    check("post_rst_busy", longint'(busy), 0);

    // Back-to-back with in_valid held and the consumer always ready.
    out_ready = 1;
    @(negedge clk);
    mode_i = 0; x_i = to_q(0.6); y_i = to_q(0.2); z_i = to_q(-0.5);
    in_valid = 1;
    for (int o = 0; o < 3; o++) begin
      bit acc;
      acc = 0;
      for (int n = 0; n < 40 && !acc; n++) begin
        @(posedge clk);
        if (in_ready) begin
          acc = 1;
          acc_cyc[o] = cyc;
        end
      end
      check("b2b_accept", longint'(acc), 1);
      @(negedge clk);
      if (o == 0) begin
        mode_i = 1; x_i = to_q(0.8); y_i = to_q(0.6); z_i = to_q(0.1);
      end else if (o == 1) begin
        mode_i = 0; x_i = to_q(-0.4); y_i = to_q(0.7); z_i = to_q(1.2);
      end else begin
        in_valid = 0;
      end
    end
    check("b2b_gap01", acc_cyc[1] - acc_cyc[0], LAT + 2);
    check("b2b_gap12", acc_cyc[2] - acc_cyc[1], LAT + 2);
    wait_result("lat_b2b");
    repeat (3) @(negedge clk);
    out_ready = 0;
    check("b2b_idle", longint'(in_ready), 1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
